// File: rtl/connect_column_ctrl.sv
// rtl/connect_column_ctrl.sv - column cursor, fill heights and turn control for the board game
// Optional CURSOR_SKIP_FULL_EN: right/left jump to the nearest non-full column.
module connect_column_ctrl #(
  parameter  int COLS    = 7,
  parameter  int ROWS    = 6,
  parameter  int PLAYERS = 2,
  localparam int CW      = $clog2(COLS),
  localparam int HW      = $clog2(ROWS + 1),
  localparam int RW      = (ROWS > 2) ? $clog2(ROWS) : 1,
  localparam int PW      = (PLAYERS > 2) ? $clog2(PLAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          put,
  input  logic          right,
  input  logic          left,
  input  logic          game_over,
  output logic [CW-1:0] cursor,
  output logic [PW-1:0] turn,
  output logic          drop_valid,
  output logic [CW-1:0] drop_col,
  output logic [RW-1:0] drop_row,
  output logic [PW-1:0] drop_player,
  output logic          invalid_move,
  output logic          board_full
);

  logic [HW-1:0] r_h [COLS];
  logic [CW-1:0] r_cursor;
  logic [PW-1:0] r_turn;
  logic          r_drop_valid;
  logic [CW-1:0] r_drop_col;
  logic [RW-1:0] r_drop_row;
  logic [PW-1:0] r_drop_player;
  logic          r_invalid;

  logic [CW-1:0] w_right_col;
  logic [CW-1:0] w_left_col;
  logic          w_full;
  logic          w_col_full;

  assign w_col_full = (r_h[r_cursor] == HW'(ROWS));

  always_comb begin
    w_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (r_h[c] != HW'(ROWS)) w_full = 1'b0;
    end
  end

`ifdef CURSOR_SKIP_FULL_EN
  // Scan outward from the cursor; if nothing qualifies the cursor stays where it is.
  always_comb begin : p_search
    int   ir;
    int   il;
    logic w_rfound;
    logic w_lfound;
    ir          = 0;
    il          = 0;
    w_rfound    = 1'b0;
    w_lfound    = 1'b0;
    w_right_col = r_cursor;
    w_left_col  = r_cursor;
    for (int k = 1; k < COLS; k++) begin
      ir = int'(r_cursor) + k;
      if (ir >= COLS) ir = ir - COLS;
      il = int'(r_cursor) - k;
      if (il < 0) il = il + COLS;
      if (!w_rfound && (r_h[CW'(ir)] != HW'(ROWS))) begin
        w_right_col = CW'(ir);
        w_rfound    = 1'b1;
      end
      if (!w_lfound && (r_h[CW'(il)] != HW'(ROWS))) begin
        w_left_col = CW'(il);
        w_lfound   = 1'b1;
      end
    end
  end
`else
  assign w_right_col = (r_cursor == CW'(COLS - 1)) ? '0 : r_cursor + CW'(1);
  assign w_left_col  = (r_cursor == '0) ? CW'(COLS - 1) : r_cursor - CW'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) r_h[c] <= '0;
      r_cursor      <= '0;
      r_turn        <= '0;
      r_drop_valid  <= 1'b0;
      r_drop_col    <= '0;
      r_drop_row    <= '0;
      r_drop_player <= '0;
      r_invalid     <= 1'b0;
    end else begin
      r_drop_valid <= 1'b0;
      r_invalid    <= 1'b0;
      if (clear) begin
        for (int c = 0; c < COLS; c++) r_h[c] <= '0;
        r_cursor <= '0;
        r_turn   <= '0;
      end else if (put) begin
        if (!game_over) begin
          if (w_col_full) begin
            r_invalid <= 1'b1;
          end else begin
            r_drop_valid      <= 1'b1;
            r_drop_col        <= r_cursor;
            r_drop_row        <= RW'(r_h[r_cursor]);
            r_drop_player     <= r_turn;
            r_h[r_cursor]     <= r_h[r_cursor] + HW'(1);
            r_turn            <= (r_turn == PW'(PLAYERS - 1)) ? '0 : r_turn + PW'(1);
          end
        end
      end else if (right && !left) begin
        r_cursor <= w_right_col;
      end else if (left && !right) begin
        r_cursor <= w_left_col;
      end
    end
  end

  assign cursor       = r_cursor;
  assign turn         = r_turn;
  assign drop_valid   = r_drop_valid;
  assign drop_col     = r_drop_col;
  assign drop_row     = r_drop_row;
  assign drop_player  = r_drop_player;
  assign invalid_move = r_invalid;
  assign board_full   = w_full;

endmodule

// File: doc/connect_column_ctrl.md
# connect_column_ctrl

Parametrised column-cursor and turn controller for the board game engine. It tracks a wrap-around column cursor, per-column fill heights and the player whose turn it is. It converts debounced button pulses into registered drop events for the board memory and win checker, and detects illegal drops (full column) internally.

## Interface
Parameters:
- COLS, 7, number of board columns (2..16)
- ROWS, 6, number of rows per column (2..15)
- PLAYERS, 2, number of players taking turns (2..4)

Derived widths:
- CW = $clog2(COLS)
- HW = $clog2(ROWS+1)
- RW = max(1,$clog2(ROWS))
- PW = max(1,$clog2(PLAYERS))

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous new-game request
- put  in  1  drop request, single-cycle pulse, already debounced
- right  in  1  cursor right, single-cycle pulse
- left  in  1  cursor left, single-cycle pulse
- game_over  in  1  from win checker; blocks drops while high
- cursor  out  CW  active column
- turn  out  PW  player to move
- drop_valid  out  1  one-cycle pulse: legal drop accepted
- drop_col  out  CW  column of accepted drop
- drop_row  out  RW  row filled (0 = bottom)
- drop_player  out  PW  player who dropped
- invalid_move  out  1  one-cycle pulse: drop rejected (column full)
- board_full  out  1  level: every column holds ROWS pieces

## Operation
- Per-column height register h[c], range 0..ROWS.
- Input priority each cycle: clear > put > right/left.
  - right and left together with no put: no action.
- clear: cursor=0, turn=0, all h=0, pulses low. Takes effect next edge, overriding all other inputs.
- put with game_over=1: ignored, no pulse, no state change.
- put with h[cursor]==ROWS:
  - invalid_move=1 for one cycle.
  - turn, heights and cursor unchanged.
- put with h[cursor]<ROWS (legal drop):
  - drop_valid=1; drop_col=cursor; drop_row=h[cursor] (value before increment); drop_player=turn.
  - h[cursor]++.
  - turn = (turn==PLAYERS-1) ? 0 : turn+1.
  - Cursor unchanged.
- right: cursor = (cursor==COLS-1) ? 0 : cursor+1.
- left: cursor = (cursor==0) ? COLS-1 : cursor-1.
- board_full = AND over columns of (h[c]==ROWS). Combinational from registered heights.
- drop_col, drop_row and drop_player hold their last values when drop_valid is low.

## Timing
- Reset (rst low, async): cursor=0, turn=0, all h=0, drop_valid=0, invalid_move=0, drop_col=0, drop_row=0, drop_player=0, board_full=0.
- All outputs except board_full are registered. Response appears one cycle after the input is sampled on the rising edge.
- Back-to-back puts on consecutive cycles are each evaluated against the heights updated by the previous cycle. No pipeline hazard.
- A put in the same cycle a column becomes full sees the pre-increment height.
- board_full rises in the cycle after the final legal drop, aligned with that drop_valid.
- rst assertion mid-operation clears all state immediately. No pulse survives reset.
- Rising edges of rst are synchronised externally. No deassertion logic is required here.

## Configuration
- CURSOR_SKIP_FULL_EN defined: right/left move the cursor to the nearest column in that direction (with wrap) whose h < ROWS.
  - If every other column is full, the cursor stays put.
  - Single-cycle search, no extra latency.
  - After a legal drop fills the cursor column, the cursor stays. The next right/left skips as above.
- Undefined: right/left step exactly one column with wrap, regardless of fill.

## Test plan
All scenarios use defaults: COLS=7, ROWS=6, PLAYERS=2.
- Reset then left pulse -> cursor=6. Right pulse -> cursor=0 (both wraps).
- Three puts at column 3 -> drop_row 0,1,2; drop_player 0,1,0; turn ends at 1; h[3]=3.
- Seven puts at column 0 -> six drop_valid pulses (rows 0..5), then invalid_move pulse; turn unchanged on the 7th.
- 42 legal drops across all columns -> board_full=1 in the same cycle as the last drop_valid. Then put -> invalid_move.
- game_over=1 with put -> no pulses, h and turn unchanged. clear -> cursor=0, turn=0, board_full=0.
- With CURSOR_SKIP_FULL_EN, columns 1 and 2 full, cursor=0, right -> cursor=3. Without the macro, same stimulus -> cursor=1.
